multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
Parametrised N-channel switch debouncer. Each channel is a 2-FF synchroniser followed by a stability counter and a registered debounced level with one-cycle up/down transition strobes. An optional shared tick input lets one prescaler serve many debouncers, so long debounce times need no wide per-channel counters. Sits between raw board pins (buttons, DIP switches) and control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
STABLE_CYCLES, 100000, consecutive counted ticks of mismatch required before the output flips (>=1)
RESET_LEVEL, 0, level loaded into every synchroniser stage and into state on reset
CNT_W, derived localparam = $clog2(STABLE_CYCLES+1), counter width, not overridable

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
tick  in  1  count enable shared by all channels; tie to 1 to count every clk
din  in  CHANNELS  raw asynchronous switch inputs
state  out  CHANNELS  debounced level per channel
trans_up  out  CHANNELS  one-cycle pulse when state[i] goes 0->1
trans_dn  out  CHANNELS  one-cycle pulse when state[i] goes 1->0
any_change  out  1  OR of all trans_up and trans_dn bits (combinational from registered pulses)

Behaviour:
- Reset (rst=1 at an edge): sync_0, sync_1 and state all become RESET_LEVEL; counters 0; trans_up/trans_dn 0. No pulse is generated by reset, including mid-count.
- Synchroniser: sync_0[i] <= din[i]; sync_1[i] <= sync_0[i] every clk, independent of tick.
- Per-channel counter, evaluated every clk with priority in this order:
  1. sync_1[i]==state[i]: cnt <= 0, regardless of tick (a bounce back clears progress).
  2. Mismatch, tick=0: cnt holds.
  3. Mismatch, tick=1, cnt==STABLE_CYCLES-1: state[i] <= ~state[i]; cnt <= 0; trans_up[i] or trans_dn[i] <= 1 matching the new level.
  4. Mismatch, tick=1, otherwise: cnt <= cnt+1.
- trans_up/trans_dn are registered. They are high for exactly the one cycle in which state holds its new value, then 0. At most one of the pair is high per channel.
- Latency with tick=1: a new level held stable on din is reflected in state after the (STABLE_CYCLES+2)th rising edge at which the level is present at din. With gated tick, the count portion is measured in tick-high cycles.
- Any single mismatch-free cycle restarts the count: pulses shorter than STABLE_CYCLES ticks never reach state.
- Channels are fully independent. Simultaneous flips on several channels each pulse in the same cycle; any_change is 1 for that cycle.
- Counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.

Optional Feature:
Macro MULTI_DEBOUNCER_EVT_LATCH_EN.
- Defined: adds ports evt_clr (in, CHANNELS), evt_up (out, CHANNELS) and evt_dn (out, CHANNELS).
  - evt_up[i]/evt_dn[i] are sticky flags, set by trans_up[i]/trans_dn[i].
  - Cleared by evt_clr[i]=1; a set in the same cycle wins over a clear.
  - Reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: CHANNELS=4, STABLE_CYCLES=4, RESET_LEVEL=1, rst for 2 clk -> state=4'b1111, trans_*=0, no pulse on rst release with din=4'b1111.
- Clean press: tick=1, din[0] 0->1 held -> state[0]=1 after 6th edge; trans_up[0]=1 exactly that one cycle; any_change=1 same cycle; other bits unchanged.
- Bounce: din[1] high 3 cycles, low 1, high 10 -> only one trans_up[1], occurring 6 edges after the final rising of din[1]; no trans_dn[1].
- Tick gating: tick high 1 cycle in 3, STABLE_CYCLES=4, din[2] 0->1 held -> state[2] flips after 4 tick-high edges following sync; drop din for 1 cycle mid-count -> count restarts.
- Simultaneous/reset mid-count: din=4'b1111 from 0 -> all four trans_up in same cycle; repeat with rst asserted after 2 ticks -> state=RESET_LEVEL, no pulses.
- With MULTI_DEBOUNCER_EVT_LATCH_EN: trans_up[3] pulse -> evt_up[3]=1 held; evt_clr[3] in same cycle as a new trans_up[3] -> evt_up[3] stays 1; evt_clr[3] alone -> 0 next cycle.

Source files
------------

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel switch debouncer with 2-FF synchronisers, tick-gated stability counters and transition strobes.
// Optional macro MULTI_DEBOUNCER_EVT_LATCH_EN adds sticky per-channel event flags (evt_up/evt_dn) cleared by evt_clr.
module multi_debouncer #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 100000,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] trans_up,
    output logic [CHANNELS-1:0] trans_dn,
`ifdef MULTI_DEBOUNCER_EVT_LATCH_EN
    input  logic [CHANNELS-1:0] evt_clr,
    output logic [CHANNELS-1:0] evt_up,
    output logic [CHANNELS-1:0] evt_dn,
`endif
    output logic                any_change
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic [CHANNELS-1:0] sync_0;
    logic [CHANNELS-1:0] sync_1;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] mismatch;
    assign mismatch   = sync_1 ^ state;
    assign any_change = |{trans_up, trans_dn};
    // two-stage synchroniser on the raw pins, runs every clock regardless of tick
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= {CHANNELS{RESET_LEVEL}};
            sync_1 <= {CHANNELS{RESET_LEVEL}};
        end else begin
            sync_0 <= din;
            sync_1 <= sync_0;
        end
    end
    // per-channel stability counter; a matching cycle clears progress, the last counted tick flips state and strobes
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                state[i]    <= RESET_LEVEL;
                cnt[i]      <= '0;
                trans_up[i] <= 1'b0;
                trans_dn[i] <= 1'b0;
            end else begin
                trans_up[i] <= 1'b0;
                trans_dn[i] <= 1'b0;
                if (!mismatch[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == LAST) begin
                        state[i]    <= ~state[i];
                        cnt[i]      <= '0;
                        trans_up[i] <= ~state[i];
                        trans_dn[i] <= state[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`ifdef MULTI_DEBOUNCER_EVT_LATCH_EN
    // sticky event flags; a transition in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_up <= '0;
            evt_dn <= '0;
        end else begin
            evt_up <= trans_up | (evt_up & ~evt_clr);
            evt_dn <= trans_dn | (evt_dn & ~evt_clr);
        end
    end
`endif
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: scoreboard bench for multi_debouncer (CHANNELS=4, STABLE_CYCLES=4, RESET_LEVEL=1).
module tb_multi_debouncer;
    localparam int   C  = 4;
    localparam int   S  = 4;
    localparam logic RL = 1'b1;
    typedef struct packed {
        logic [C-1:0] st;
        logic [C-1:0] up;
        logic [C-1:0] dn;
        logic [C-1:0] eu;
        logic [C-1:0] ed;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [C-1:0] din;
    logic [C-1:0] evt_clr;
    logic [C-1:0] state;
    logic [C-1:0] trans_up;
    logic [C-1:0] trans_dn;
    logic         any_change;
`ifdef MULTI_DEBOUNCER_EVT_LATCH_EN
    logic [C-1:0] evt_up;
    logic [C-1:0] evt_dn;
`endif
    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           hit;
    int           nup;
    int           ndn;
    int           npulse;
    logic [C-1:0] m0, m1, ms, mu, md, meu, med;
    int           run [C];

    multi_debouncer #(.CHANNELS(C), .STABLE_CYCLES(S), .RESET_LEVEL(RL)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .din(din),
        .state(state),
        .trans_up(trans_up),
        .trans_dn(trans_dn),
`ifdef MULTI_DEBOUNCER_EVT_LATCH_EN
        .evt_clr(evt_clr),
        .evt_up(evt_up),
        .evt_dn(evt_dn),
`endif
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model: a level must survive S counted ticks after the 2-clock synchroniser delay
    task automatic predict();
        logic [C-1:0] nu, nd;
        exp_t e;
        if (rst) begin
            m0 = {C{RL}};
            m1 = {C{RL}};
            ms = {C{RL}};
            mu = '0;
            md = '0;
            meu = '0;
            med = '0;
            for (int i = 0; i < C; i++) run[i] = 0;
        end else begin
            meu = mu | (meu & ~evt_clr);
            med = md | (med & ~evt_clr);
            nu = '0;
            nd = '0;
            for (int i = 0; i < C; i++) begin
                if (m1[i] == ms[i]) run[i] = 0;
                else if (tick) begin
                    run[i]++;
                    if (run[i] == S) begin
                        run[i] = 0;
                        nu[i] = ~ms[i];
                        nd[i] = ms[i];
                        ms[i] = ~ms[i];
                    end
                end
            end
            mu = nu;
            md = nd;
            m1 = m0;
            m0 = din;
        end
        e.st = ms;
        e.up = mu;
        e.dn = md;
        e.eu = meu;
        e.ed = med;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("trans_up", 32'(trans_up), 32'(e.up));
        check("trans_dn", 32'(trans_dn), 32'(e.dn));
        check("any_change", 32'(any_change), 32'(|{e.up, e.dn}));
`ifdef MULTI_DEBOUNCER_EVT_LATCH_EN
        check("evt_up", 32'(evt_up), 32'(e.eu));
        check("evt_dn", 32'(evt_dn), 32'(e.ed));
`endif
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b1;
        din = '1;
        evt_clr = '0;
        repeat (2) cyc();
        check("rst_state", 32'(state), 32'hF);
        check("rst_up", 32'(trans_up), 32'h0);
        check("rst_dn", 32'(trans_dn), 32'h0);
        rst = 1'b0;
        npulse = 0;
        repeat (3) begin
            cyc();
            npulse += int'(any_change);
        end
        check("rst_release_pulses", 32'(npulse), 32'd0);
        din = '0;
        repeat (5) cyc();
        check("fall_early", 32'(state), 32'hF);
        cyc();
        check("fall_state", 32'(state), 32'h0);
        check("fall_dn", 32'(trans_dn), 32'hF);
        check("fall_any", 32'(any_change), 32'd1);
        cyc();
        check("fall_dn_once", 32'(trans_dn), 32'h0);
        din[0] = 1'b1;
        repeat (5) cyc();
        check("press_early", 32'(state), 32'h0);
        cyc();
        check("press_state", 32'(state), 32'h1);
        check("press_up", 32'(trans_up), 32'h1);
        check("press_any", 32'(any_change), 32'd1);
        cyc();
        check("press_up_once", 32'(trans_up), 32'h0);
        din[1] = 1'b1;
        repeat (3) cyc();
        din[1] = 1'b0;
        cyc();
        din[1] = 1'b1;
        hit = 0;
        nup = 0;
        ndn = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (trans_up[1]) begin
                nup++;
                hit = k;
            end
            if (trans_dn[1]) ndn++;
        end
        check("bounce_edge", 32'(hit), 32'd6);
        check("bounce_nup", 32'(nup), 32'd1);
        check("bounce_ndn", 32'(ndn), 32'd0);
        din[2] = 1'b1;
        hit = 0;
        for (int c = 0; c < 16; c++) begin
            tick = (c % 3 == 0);
            cyc();
            if (trans_up[2]) hit = c + 1;
        end
        check("gate_up_edge", 32'(hit), 32'd13);
        hit = 0;
        ndn = 0;
        for (int c = 0; c < 25; c++) begin
            tick = (c % 3 == 0);
            din[2] = (c == 7);
            cyc();
            if (trans_dn[2]) begin
                hit = c + 1;
                ndn++;
            end
        end
        check("gate_restart_edge", 32'(hit), 32'd22);
        check("gate_restart_ndn", 32'(ndn), 32'd1);
        tick = 1'b1;
        din = '0;
        repeat (8) cyc();
        din = '1;
        repeat (5) cyc();
        check("simul_early", 32'(state), 32'h0);
        cyc();
        check("simul_up", 32'(trans_up), 32'hF);
        check("simul_any", 32'(any_change), 32'd1);
        din = '0;
        repeat (8) cyc();
        din = '1;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        check("midrst_state", 32'(state), 32'hF);
        check("midrst_up", 32'(trans_up), 32'h0);
        rst = 1'b0;
        npulse = 0;
        repeat (8) begin
            cyc();
            npulse += int'(any_change);
        end
        check("midrst_pulses", 32'(npulse), 32'd0);
`ifdef MULTI_DEBOUNCER_EVT_LATCH_EN
        din = '0;
        repeat (8) cyc();
        evt_clr = '1;
        cyc();
        evt_clr = '0;
        check("evt_clr_all_up", 32'(evt_up), 32'h0);
        check("evt_clr_all_dn", 32'(evt_dn), 32'h0);
        din[3] = 1'b1;
        repeat (6) cyc();
        check("evt_trans_up3", 32'(trans_up), 32'h8);
        evt_clr[3] = 1'b1;
        cyc();
        evt_clr = '0;
        check("evt_set_wins", 32'(evt_up), 32'h8);
        cyc();
        check("evt_held", 32'(evt_up), 32'h8);
        evt_clr[3] = 1'b1;
        cyc();
        evt_clr = '0;
        check("evt_cleared", 32'(evt_up), 32'h0);
`endif
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) din[$urandom_range(0, C - 1)] ^= 1'b1;
            tick = ($urandom_range(0, 3) != 0);
            evt_clr = ($urandom_range(0, 7) == 0) ? C'($urandom) : '0;
            rst = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
